uart_apb_bridge: RTL and testbench
==================================

# uart_apb_bridge

UART-to-APB debug bridge: receives command frames from a host over an 8N1 UART link and issues single APB read or write transfers as the bus initiator. It returns an acknowledge, plus read data for reads, over the UART transmit line. It sits between the board's debug UART pins and the system APB, and drives the same APB slave ports that peripherals such as the UART controller expose.

## Interface

- DIVISOR, 415: bit period is DIVISOR+1 clk cycles; fixed at build time, not runtime-configurable.
- ADDR_W, 32: width of apb_PADDR.
- TIMEOUT, 1000000: maximum clk cycles allowed between bytes of one frame.

Ports:

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- uart_rx  in  1  serial input, idle high, asynchronous to clk.
- uart_tx  out  1  serial output, idle high.
- apb_PADDR  out  ADDR_W  transfer address.
- apb_PSEL  out  1  select.
- apb_PENABLE  out  1  access phase.
- apb_PWRITE  out  1  1 = write.
- apb_PWDATA  out  32  write data.
- apb_PRDATA  in  32  read data, sampled when PENABLE & PREADY.
- apb_PREADY  in  1  slave ready.
- busy  out  1  high from the first command byte until the last response stop bit ends.

## Operation

- Frame format, multi-byte fields little-endian:
  - Write: 0x57 'W', 4 address bytes, 4 data bytes. Response: 0x4B 'K'.
  - Read: 0x52 'R', 4 address bytes. Response: 0x4B, then 4 PRDATA bytes.
  - Any other first byte: response 0x3F '?'. No APB transfer.
- apb_PADDR = received address[ADDR_W-1:0]. Upper address bits are ignored.
- Receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A low level in idle starts a candidate start bit. It is rechecked after (DIVISOR+1)/2 cycles; if high there, the start is false and the receiver returns to idle.
  - 8 data bits are sampled LSB first at bit centers, then the stop bit.
  - Stop bit = 1: byte valid, one-cycle strobe. Stop bit = 0: framing error, and the byte is discarded.
- Parser FSM states: IDLE, ADDR (count 0-3), DATA (count 0-3), SETUP, ACCESS, RESP.
  - IDLE -> ADDR on 0x57 or 0x52; the command is latched.
  - IDLE -> RESP('?') on any other valid byte.
  - ADDR -> DATA after 4 bytes if the command is W; -> SETUP if the command is R.
  - DATA -> SETUP after 4 bytes.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1 until PREADY=1. On that cycle PRDATA is captured for a read, then -> RESP.
  - RESP: sends 1 or 5 bytes back-to-back (no idle between stop and next start), then -> IDLE.
- A framing error in ADDR or DATA aborts the frame: -> IDLE, no response.
- Timeout: a cycle counter clears on each valid byte. Reaching TIMEOUT in ADDR or DATA -> IDLE, no response.
- Bytes received in SETUP, ACCESS or RESP are dropped. The receiver keeps running so it stays byte-aligned.
- PADDR, PWRITE and PWDATA hold their values from SETUP until the next SETUP.
- Transmitter: start 0, 8 data bits LSB first, stop 1. Each bit is DIVISOR+1 cycles; one byte is 10*(DIVISOR+1) cycles.

## Timing

- Reset values:
  - uart_tx=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0.
  - FSM in IDLE, receiver idle, timeout counter cleared.
- Reset mid-transfer drops PSEL/PENABLE on the next edge. A byte in flight is abandoned with uart_tx=1.
- SETUP is entered the cycle after the strobe of the last frame byte.
- An ACCESS with PREADY already high lasts 1 cycle, so the total APB transfer is 2 cycles. There is no APB timeout: the bridge waits indefinitely for PREADY.
- The response start bit begins on uart_tx within 2 cycles after the PREADY cycle.
- busy rises the cycle after the command-byte strobe and falls the cycle after the final stop bit completes.
- The receive strobe occurs at the stop-bit sample point, about 9.5 bit periods after the start edge.
- The receiver tolerates ±2% baud mismatch.

## Test plan

All scenarios use DIVISOR=7 (8 cycles/bit) and TIMEOUT=500.

- Write: send 57 10 00 00 00 EF BE AD DE with PREADY tied 1 -> one 2-cycle APB write, PADDR=0x10, PWDATA=0xDEADBEEF; uart_tx sends 0x4B; busy falls afterwards.
- Read with wait states: send 52 04 00 00 00; PREADY held low for 5 ACCESS cycles, PRDATA=0x12345678 -> PENABLE high for 6 cycles; response 4B 78 56 34 12 back-to-back, 400 cycles total.
- Unknown command: send 0x41 -> response 0x3F, PSEL never asserted.
- Timeout: send 57 10 00, then idle 600 cycles, then 52 00 00 00 00 -> the first frame is discarded with no APB write; the second read completes with response 0x4B plus 4 data bytes.
- Errors: a byte with stop bit 0 inside a frame -> no response, next valid frame accepted. A 3-cycle low glitch on uart_rx -> no byte decoded.
- Reset asserted during ACCESS -> PSEL=0 and uart_tx=1 next cycle; the next write frame executes normally.

Source files
------------

// File: rtl/uart_apb_bridge_if.sv
// APB signal bundle between the UART debug bridge (initiator) and the system APB.
interface uart_apb_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/uart_apb_bridge.sv
// UART-to-APB debug bridge: 8N1 command frames in, single APB transfers out,
// acknowledge (plus read data) returned over uart_tx.
module uart_apb_bridge #(
  parameter int unsigned DIVISOR = 415,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              busy,
  uart_apb_bridge_if.master apb
);

  localparam int unsigned CNT_W = (DIVISOR < 1) ? 1 : $clog2(DIVISOR + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((DIVISOR + 1) / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

  rx_state_e        rx_state_q;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q, rx_ferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RxIdle;
            end else begin
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RxBreak;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        // After a framing error the line may still be low; wait for a mark so the
        // tail of the bad character is not mistaken for a new start bit.
        RxBreak: begin
          if (rx_sync_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // ---------------- parser, APB initiator and transmitter ----------------
  typedef enum logic [2:0] {StIdle, StAddr, StData, StSetup, StAccess, StResp} state_e;

  state_e            state_q;
  logic              cmd_write_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       addr_q, wdata_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [39:0]       resp_q;
  logic [2:0]        resp_left_q;
  logic              tx_active_q;
  logic [3:0]        tx_bit_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [7:0]        tx_byte_q;
  logic              tx_q;
  logic              psel_q, penable_q, pwrite_q, busy_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;

  logic [31:0] addr_next, wdata_next;
  logic        tx_bit_end, tx_byte_end;

  assign addr_next   = {rx_shift_q, addr_q[31:8]};
  assign wdata_next  = {rx_shift_q, wdata_q[31:8]};
  assign tx_bit_end  = (tx_cnt_q == BIT_LAST);
  assign tx_byte_end = tx_active_q && tx_bit_end && (tx_bit_q == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_write_q <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      to_cnt_q    <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      tx_active_q <= 1'b0;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      tx_byte_q   <= '0;
      tx_q        <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          to_cnt_q <= '0;
          if (rx_valid_q) begin
            busy_q <= 1'b1;
            if (rx_shift_q == 8'h57 || rx_shift_q == 8'h52) begin
              cmd_write_q <= (rx_shift_q == 8'h57);
              byte_cnt_q  <= '0;
              state_q     <= StAddr;
            end else begin
              resp_q      <= {32'h0, 8'h3F};
              resp_left_q <= 3'd1;
              state_q     <= StResp;
            end
          end
        end
        StAddr: begin
          if (rx_ferr_q || (!rx_valid_q && to_cnt_q == TO_LAST)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (rx_valid_q) begin
            to_cnt_q   <= '0;
            addr_q     <= addr_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (cmd_write_q) begin
                state_q <= StData;
              end else begin
                psel_q   <= 1'b1;
                paddr_q  <= addr_next[ADDR_W-1:0];
                pwrite_q <= 1'b0;
                state_q  <= StSetup;
              end
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        StData: begin
          if (rx_ferr_q || (!rx_valid_q && to_cnt_q == TO_LAST)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (rx_valid_q) begin
            to_cnt_q   <= '0;
            wdata_q    <= wdata_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              psel_q   <= 1'b1;
              paddr_q  <= addr_q[ADDR_W-1:0];
              pwrite_q <= 1'b1;
              pwdata_q <= wdata_next;
              state_q  <= StSetup;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (apb.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= StResp;
            if (pwrite_q) begin
              resp_q      <= {32'h0, 8'h4B};
              resp_left_q <= 3'd1;
            end else begin
              resp_q      <= {apb.PRDATA, 8'h4B};
              resp_left_q <= 3'd5;
            end
          end
        end
        StResp: begin
          // The next byte loads on the last stop-bit cycle so bytes go out back-to-back.
          if (!tx_active_q || tx_byte_end) begin
            if (resp_left_q != 3'd0) begin
              tx_active_q <= 1'b1;
              tx_byte_q   <= resp_q[7:0];
              resp_q      <= {8'h0, resp_q[39:8]};
              resp_left_q <= resp_left_q - 3'd1;
              tx_bit_q    <= '0;
              tx_cnt_q    <= '0;
              tx_q        <= 1'b0;
            end else begin
              tx_active_q <= 1'b0;
              tx_q        <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end
          end else if (tx_bit_end) begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 4'd1;
            tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_q[tx_bit_q[2:0]];
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx     = tx_q;
  assign busy        = busy_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench for uart_apb_bridge: vector table of frames, scoreboard of response bytes,
// APB completer model with wait states, plus timeout/framing/glitch/reset sequences.
module tb_uart_apb_bridge;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    bit          exp_apb;
    bit          exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          exp_nresp;
    logic [39:0] exp_resp;  // response bytes, first byte in [7:0]
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  logic uart_tx;
  logic busy;

  uart_apb_bridge_if #(.ADDR_W(32)) apb_bus ();

  uart_apb_bridge #(
    .DIVISOR(7),
    .ADDR_W (32),
    .TIMEOUT(500)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .busy   (busy),
    .apb    (apb_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_q[$];
  int         starts_q[$];
  int         tx_count    = 0;
  int         xfer_count  = 0;
  int         setup_cnt   = 0;
  int         enable_cnt  = 0;
  int         proto_err   = 0;
  int         pready_cyc  = 0;
  int         cur_waits   = 0;
  int         acc         = 0;
  logic [31:0] cur_prdata = '0;
  logic [31:0] last_addr, last_wdata;
  logic        last_write;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // APB completer: PREADY rises after cur_waits low ACCESS cycles; also records transfers.
  initial begin
    apb_bus.PREADY = 1'b0;
    apb_bus.PRDATA = '0;
    forever begin
      @(negedge clk);
      apb_bus.PRDATA = cur_prdata;
      if (apb_bus.PSEL === 1'b1 && apb_bus.PENABLE === 1'b1) begin
        apb_bus.PREADY = (acc == cur_waits);
        enable_cnt++;
        if (apb_bus.PREADY) begin
          acc        = 0;
          xfer_count++;
          last_addr  = apb_bus.PADDR;
          last_write = apb_bus.PWRITE;
          last_wdata = apb_bus.PWDATA;
          pready_cyc = cyc;
        end else begin
          acc++;
        end
      end else begin
        apb_bus.PREADY = 1'b0;
        acc = 0;
        if (apb_bus.PSEL === 1'b1) setup_cnt++;
        if (apb_bus.PENABLE === 1'b1) proto_err++;
      end
    end
  end

  // UART receive monitor on uart_tx; pops the scoreboard per decoded byte.
  initial begin : tx_mon
    int         st;
    logic [7:0] b;
    bit         ok;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        st = cyc;
        repeat (4) @(negedge clk);
        ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (8) @(negedge clk);
        ok = ok && (uart_tx === 1'b1);
        tx_count++;
        starts_q.push_back(st);
        check("tx_framing", ok, 1);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %02h, expected no byte", b);
        end else begin
          check("tx_byte", b, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic uart_send(input logic [7:0] b, input bit stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (8) @(negedge clk);
    end
    uart_rx = stop;
    repeat (8) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_idle(output int fall, output bit ok);
    ok   = 1'b0;
    fall = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok   = 1'b1;
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    int x0;
    int fall;
    int d;
    bit ok;
    x0         = xfer_count;
    setup_cnt  = 0;
    enable_cnt = 0;
    tx_count   = 0;
    starts_q.delete();
    cur_waits  = v.waits;
    cur_prdata = v.prdata;
    for (int i = 0; i < v.exp_nresp; i++) sb_q.push_back(v.exp_resp[8*i +: 8]);

    uart_send(v.cmd, 1'b1);
    check($sformatf("v%0d_busy_after_cmd", idx), busy, 1);
    if (v.cmd == 8'h57 || v.cmd == 8'h52)
      for (int i = 0; i < 4; i++) uart_send(v.addr[8*i +: 8], 1'b1);
    if (v.cmd == 8'h57)
      for (int i = 0; i < 4; i++) uart_send(v.wdata[8*i +: 8], 1'b1);

    wait_idle(fall, ok);
    check($sformatf("v%0d_busy_fall", idx), ok, 1);
    check($sformatf("v%0d_xfers", idx), xfer_count - x0, v.exp_apb);
    check($sformatf("v%0d_setup_cycles", idx), setup_cnt, v.exp_apb);
    if (v.exp_apb) begin
      check($sformatf("v%0d_paddr", idx), last_addr, v.exp_addr);
      check($sformatf("v%0d_pwrite", idx), last_write, v.exp_write);
      if (v.exp_write) check($sformatf("v%0d_pwdata", idx), last_wdata, v.exp_wdata);
      check($sformatf("v%0d_enable_cycles", idx), enable_cnt, v.waits + 1);
      if (starts_q.size() > 0) begin
        d = starts_q[0] - pready_cyc;
        if (d < 1 || d > 2) begin
          n_fail++;
          $display("FAIL v%0d_resp_latency: got %0d cycles, expected 1..2", idx, d);
        end
        n_tests++;
      end
    end
    check($sformatf("v%0d_tx_bytes", idx), tx_count, v.exp_nresp);
    if (starts_q.size() == v.exp_nresp && v.exp_nresp > 0) begin
      for (int i = 1; i < v.exp_nresp; i++)
        check($sformatf("v%0d_gap%0d", idx, i), starts_q[i] - starts_q[i-1], 80);
      check($sformatf("v%0d_busy_fall_time", idx), fall - starts_q[v.exp_nresp-1], 80);
    end
    check($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int  x0;
    bit  ok;

    //         cmd    addr          wdata         prdata        wt  apb  wr  exp_addr      exp_wdata    n  resp
    vecs[0] = '{8'h57, 32'h00000010, 32'hDEADBEEF, 32'h0,        0, 1'b1, 1'b1, 32'h00000010,
                32'hDEADBEEF, 1, 40'h4B};
    vecs[1] = '{8'h52, 32'h00000004, 32'h0,        32'h12345678, 5, 1'b1, 1'b0, 32'h00000004,
                32'h0,        5, 40'h12_34_56_78_4B};
    vecs[2] = '{8'h41, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b0, 32'h0,
                32'h0,        1, 40'h3F};
    vecs[3] = '{8'h57, 32'hA5A50100, 32'h01234567, 32'h0,        2, 1'b1, 1'b1, 32'hA5A50100,
                32'h01234567, 1, 40'h4B};
    vecs[4] = '{8'h52, 32'hFFFFFFFC, 32'h0,        32'hCAFEF00D, 0, 1'b1, 1'b0, 32'hFFFFFFFC,
                32'h0,        5, 40'hCA_FE_F0_0D_4B};
    vecs[5] = '{8'h52, 32'h00000000, 32'h0,        32'h89ABCDEF, 1, 1'b1, 1'b0, 32'h00000000,
                32'h0,        5, 40'h89_AB_CD_EF_4B};
    vecs[6] = '{8'h57, 32'h00000020, 32'h55AA33CC, 32'h0,        0, 1'b1, 1'b1, 32'h00000020,
                32'h55AA33CC, 1, 40'h4B};
    vecs[7] = '{8'h57, 32'h00000044, 32'h0BADF00D, 32'h0,        3, 1'b1, 1'b1, 32'h00000044,
                32'h0BADF00D, 1, 40'h4B};

    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_psel", apb_bus.PSEL, 0);
    check("rst_penable", apb_bus.PENABLE, 0);
    check("rst_pwrite", apb_bus.PWRITE, 0);
    check("rst_paddr", apb_bus.PADDR, 0);
    check("rst_pwdata", apb_bus.PWDATA, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 5; i++) apply(i, vecs[i]);

    // Partial write frame left to time out, then a full read.
    tx_count = 0;
    x0 = xfer_count;
    uart_send(8'h57, 1'b1);
    uart_send(8'h10, 1'b1);
    uart_send(8'h00, 1'b1);
    repeat (600) @(negedge clk);
    check("timeout_busy", busy, 0);
    check("timeout_no_xfer", xfer_count - x0, 0);
    check("timeout_no_resp", tx_count, 0);
    apply(5, vecs[5]);

    // Framing error inside the address field aborts the frame silently.
    tx_count = 0;
    x0 = xfer_count;
    uart_send(8'h57, 1'b1);
    uart_send(8'h10, 1'b1);
    uart_send(8'hFF, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_busy", busy, 0);
    check("ferr_no_xfer", xfer_count - x0, 0);
    check("ferr_no_resp", tx_count, 0);
    apply(6, vecs[6]);

    // 3-cycle low glitch must not decode as a byte.
    tx_count = 0;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_no_resp", tx_count, 0);

    // Reset while the bridge waits in ACCESS.
    tx_count   = 0;
    cur_waits  = 1000;
    cur_prdata = 32'h11111111;
    uart_send(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(8'h08, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (apb_bus.PSEL === 1'b1 && apb_bus.PENABLE === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstacc_reached_access", ok, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstacc_psel", apb_bus.PSEL, 0);
    check("rstacc_penable", apb_bus.PENABLE, 0);
    check("rstacc_uart_tx", uart_tx, 1);
    check("rstacc_busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rstacc_no_resp", tx_count, 0);
    apply(7, vecs[7]);

    check("scoreboard_empty", sb_q.size(), 0);
    check("apb_protocol_errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
